// File: rtl/tilt_move_pkg.sv
// Shared definitions for the tilt-to-move block.
//   - Bit positions of the four move directions inside move_pulses / blocked.
//   - dir_t: per-axis direction pair, at most one bit set.
//   - level_width(): width of a speed-level bus able to hold 0..num_levels.
package tilt_move_pkg;

  localparam int X_INC = 3;
  localparam int X_DEC = 2;
  localparam int Y_INC = 1;
  localparam int Y_DEC = 0;

  typedef struct packed {
    logic inc;
    logic dec;
  } dir_t;

  function automatic int level_width(input int num_levels);
    return $clog2(num_levels + 1);
  endfunction

endpackage

// File: rtl/tilt_axis_rate.sv
// One axis of the tilt-to-move converter.
// Turns an unsigned tilt sample into a direction and a quantised speed
// level, then uses a phase accumulator stepped on each base tick to emit
// move pulses at a rate of level/ACC_TOP per tick.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   enable       0 holds the accumulator at 0 (no pulses)
//   tick         one-cycle base tick shared by both axes
//   tilt         accelerometer sample, centre = 2**(TILT_WIDTH-1)
//   blocked_inc  wall in the increasing direction
//   blocked_dec  wall in the decreasing direction
//   pulse_inc    registered one-cycle move pulse, increasing direction
//   pulse_dec    registered one-cycle move pulse, decreasing direction
//   level        registered speed level (1-cycle latency)
module tilt_axis_rate
  import tilt_move_pkg::*;
#(
  parameter int TILT_WIDTH  = 8,
  parameter int DEADZONE    = 16,
  parameter int LEVEL_SHIFT = 4,
  parameter int NUM_LEVELS  = 7,
  parameter int ACC_TOP     = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                tick,
  input  logic [TILT_WIDTH-1:0]               tilt,
  input  logic                                blocked_inc,
  input  logic                                blocked_dec,
  output logic                                pulse_inc,
  output logic                                pulse_dec,
  output logic [level_width(NUM_LEVELS)-1:0]  level
);

  localparam int LW = level_width(NUM_LEVELS);
  localparam int AW = $clog2(ACC_TOP + NUM_LEVELS);

  localparam logic [TILT_WIDTH-1:0] CENTRE  = TILT_WIDTH'(2 ** (TILT_WIDTH - 1));
  localparam logic [TILT_WIDTH-1:0] MAG_MAX = TILT_WIDTH'(2 ** (TILT_WIDTH - 1) - 1);
  localparam logic [TILT_WIDTH-1:0] DZ      = TILT_WIDTH'(DEADZONE);
  localparam logic [TILT_WIDTH-1:0] DZ_P1   = TILT_WIDTH'(DEADZONE + 1);
  localparam logic [TILT_WIDTH-1:0] NL_T    = TILT_WIDTH'(NUM_LEVELS);
  localparam logic [AW-1:0]         ACC_MOD = AW'(ACC_TOP);

  dir_t                  dir;
  dir_t                  dir_q;
  logic [TILT_WIDTH-1:0] mag_raw;
  logic [TILT_WIDTH-1:0] mag;
  logic [TILT_WIDTH-1:0] steps;
  logic [LW-1:0]         level_d;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         sum;
  logic                  blk;
  logic                  clear;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dir     = '0;
    mag_raw = '0;
    mag     = '0;
    steps   = '0;
    level_d = '0;

    dir.inc = (tilt > CENTRE);
    dir.dec = (tilt < CENTRE);

    // Full-scale negative tilt (tilt=0) is one count larger than positive
    // full scale; saturate so both extremes share the same top magnitude.
    mag_raw = dir.dec ? (CENTRE - tilt) : (tilt - CENTRE);
    mag     = (mag_raw > MAG_MAX) ? MAG_MAX : mag_raw;

    if (mag > DZ) begin
      steps   = (mag - DZ_P1) >> LEVEL_SHIFT;
      level_d = (steps >= NL_T) ? LW'(NUM_LEVELS) : (LW'(steps) + LW'(1));
    end
  end

  assign blk   = (dir.inc & blocked_inc) | (dir.dec & blocked_dec);
  // A direction change, a wall or zero speed restarts the phase from 0, so
  // motion after any of these always begins with a full accumulation.
  assign clear = !enable || (level_d == '0) || (dir != dir_q) || blk;
  assign sum   = acc + AW'(level_d);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      dir_q     <= '0;
      pulse_inc <= 1'b0;
      pulse_dec <= 1'b0;
      level     <= '0;
    end else begin
      level     <= level_d;
      dir_q     <= dir;
      pulse_inc <= 1'b0;
      pulse_dec <= 1'b0;
      if (clear) begin
        acc <= '0;
      end else if (tick) begin
        // NUM_LEVELS < ACC_TOP, so one subtraction always brings sum below
        // ACC_TOP and a single tick yields at most one pulse.
        if (sum >= ACC_MOD) begin
          acc       <= sum - ACC_MOD;
          pulse_inc <= dir.inc;
          pulse_dec <= dir.dec;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/tilt_rate_mover.sv
// Converts X/Y accelerometer tilt samples into one-cycle ball-move pulses
// whose rate follows tilt magnitude. Owns the shared base tick counter and
// maps each axis onto the move_pulses / blocked bit positions.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   enable       0 holds both accumulators at 0 (no pulses)
//   x_tilt       X sample, unsigned, centre = 2**(TILT_WIDTH-1)
//   y_tilt       Y sample
//   blocked      wall flags {x_inc, x_dec, y_inc, y_dec}
//   move_pulses  one-cycle pulses {x_inc, x_dec, y_inc, y_dec}
//   x_level      registered X speed level
//   y_level      registered Y speed level
module tilt_rate_mover
  import tilt_move_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ  = 100000000,
  parameter int BASE_TICK_HZ      = 1024,
  parameter int TILT_WIDTH        = 8,
  parameter int DEADZONE          = 16,
  parameter int LEVEL_SHIFT       = 4,
  parameter int NUM_LEVELS        = 7,
  parameter int ACC_TOP           = 16,
  parameter int CNTR_WIDTH        = 32,
  parameter int SIMULATE          = 0,
  parameter int SIMULATE_TICK_CNT = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [TILT_WIDTH-1:0]               x_tilt,
  input  logic [TILT_WIDTH-1:0]               y_tilt,
  input  logic [3:0]                          blocked,
  output logic [3:0]                          move_pulses,
  output logic [level_width(NUM_LEVELS)-1:0]  x_level,
  output logic [level_width(NUM_LEVELS)-1:0]  y_level
);

  localparam logic [CNTR_WIDTH-1:0] TICK_TOP = (SIMULATE != 0)
      ? CNTR_WIDTH'(SIMULATE_TICK_CNT)
      : CNTR_WIDTH'(CLK_FREQUENCY_HZ / BASE_TICK_HZ - 1);

  logic [CNTR_WIDTH-1:0] tick_cnt;
  logic                  tick;

  assign tick = (tick_cnt == TICK_TOP);

  // Free-running regardless of enable so both axes stay phase-aligned to
  // the same base tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNTR_WIDTH'(1);
    end
  end

  tilt_axis_rate #(
    .TILT_WIDTH  (TILT_WIDTH),
    .DEADZONE    (DEADZONE),
    .LEVEL_SHIFT (LEVEL_SHIFT),
    .NUM_LEVELS  (NUM_LEVELS),
    .ACC_TOP     (ACC_TOP)
  ) u_x_axis (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .tilt        (x_tilt),
    .blocked_inc (blocked[X_INC]),
    .blocked_dec (blocked[X_DEC]),
    .pulse_inc   (move_pulses[X_INC]),
    .pulse_dec   (move_pulses[X_DEC]),
    .level       (x_level)
  );

  tilt_axis_rate #(
    .TILT_WIDTH  (TILT_WIDTH),
    .DEADZONE    (DEADZONE),
    .LEVEL_SHIFT (LEVEL_SHIFT),
    .NUM_LEVELS  (NUM_LEVELS),
    .ACC_TOP     (ACC_TOP)
  ) u_y_axis (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .tilt        (y_tilt),
    .blocked_inc (blocked[Y_INC]),
    .blocked_dec (blocked[Y_DEC]),
    .pulse_inc   (move_pulses[Y_INC]),
    .pulse_dec   (move_pulses[Y_DEC]),
    .level       (y_level)
  );

endmodule
